// File: rtl/fifo_pkg.sv
// Shared helpers for the FIFO family.
//   cnt_width(depth) : width of an occupancy counter able to hold depth+1
//   is_pow2(value)   : true when value is a non-zero power of two
package fifo_pkg;

  // Occupancy of a FWFT FIFO reaches depth+1 (RAM entries plus head word).
  function automatic int cnt_width(input int depth);
    return $clog2(depth + 2);
  endfunction

  function automatic bit is_pow2(input int value);
    return (value > 0) && ((value & (value - 1)) == 0);
  endfunction

endpackage : fifo_pkg

// File: rtl/simple_dpram_sclk.sv
// Single-clock simple dual-port RAM with a registered read port.
// A read that hits the address being written in the same cycle returns the
// new write data when ENABLE_BYPASS is set. The read register only updates
// on rd_en, so dout holds between reads.
//   clk   : clock, rising edge
//   raddr : read address          rd_en : read enable
//   waddr : write address         wr_en : write enable
//   din   : write data            dout  : registered read data
module simple_dpram_sclk #(
  parameter int ADDR_WIDTH    = 4,
  parameter int DATA_WIDTH    = 32,
  parameter int NUM_MEM       = 16,
  parameter bit ENABLE_BYPASS = 1'b1
) (
  input  logic                  clk,
  input  logic [ADDR_WIDTH-1:0] raddr,
  input  logic                  rd_en,
  input  logic [ADDR_WIDTH-1:0] waddr,
  input  logic                  wr_en,
  input  logic [DATA_WIDTH-1:0] din,
  output logic [DATA_WIDTH-1:0] dout
);

  logic [DATA_WIDTH-1:0] mem [NUM_MEM];

  // NOTE: the storage array has no reset so it maps onto block RAM; the
  // consumer must qualify dout with its own valid flag.
  always_ff @(posedge clk) begin
    if (wr_en) mem[waddr] <= din;
  end

  always_ff @(posedge clk) begin
    if (rd_en) begin
      if (ENABLE_BYPASS && wr_en && (waddr == raddr)) dout <= din;
      else                                            dout <= mem[raddr];
    end
  end

endmodule : simple_dpram_sclk

// File: rtl/sync_fifo_fwft.sv
// First-word-fall-through FIFO over simple_dpram_sclk. The head word is the
// RAM read register itself; the control logic prefetches into it whenever it
// is empty or being consumed, using the RAM bypass for write-through.
//   clk, rst     : clock, synchronous active-high reset
//   flush        : synchronous clear, rst has priority
//   in_valid/in_ready/in_data    : producer handshake
//   out_valid/out_ready/out_data : consumer handshake, out_data is RAM dout
//   count        : RAM entries plus head word (0..DEPTH+1)
//   almost_full  : count >= ALMOST_FULL_LVL
module sync_fifo_fwft
  import fifo_pkg::*;
#(
  parameter int DATA_WIDTH      = 32,
  parameter int DEPTH           = 16,
  parameter int ALMOST_FULL_LVL = DEPTH - 2
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         flush,
  input  logic                         in_valid,
  output logic                         in_ready,
  input  logic [DATA_WIDTH-1:0]        in_data,
  output logic                         out_valid,
  input  logic                         out_ready,
  output logic [DATA_WIDTH-1:0]        out_data,
  output logic [cnt_width(DEPTH)-1:0]  count,
  output logic                         almost_full
);

  localparam int AW    = $clog2(DEPTH);
  localparam int CNT_W = cnt_width(DEPTH);

  if (!is_pow2(DEPTH) || DEPTH < 2) begin : g_bad_depth
    $fatal(1, "sync_fifo_fwft: DEPTH must be a power of two and at least 2");
  end

  logic [AW-1:0]    wr_ptr, rd_ptr;
  logic [CNT_W-1:0] ram_cnt, ram_cnt_next;
  logic             in_fire, out_fire, wr_en, rd_en;

  // Readiness depends on registered state only, so there is no
  // combinational path from out_ready back to the producer.
  assign in_ready = !rst && (ram_cnt != CNT_W'(DEPTH));
  assign in_fire  = in_valid && in_ready;
  assign out_fire = out_valid && out_ready;

  // A flush discards any word offered in the same cycle.
  assign wr_en = in_fire && !flush;

  // Refill the head whenever it is free or leaving, from the RAM or, when the
  // RAM is empty, straight from the incoming word via the bypass path
  // (rd_ptr == wr_ptr in that case).
  assign rd_en = ((ram_cnt != '0) || in_fire) && (!out_valid || out_ready)
                 && !flush && !rst;

  // NOTE: every signal assigned in always_comb gets a value on every path,
  // here a default up front, so no latch is inferred.
  always_comb begin
    ram_cnt_next = ram_cnt;
    if (wr_en) ram_cnt_next = ram_cnt_next + CNT_W'(1);
    if (rd_en) ram_cnt_next = ram_cnt_next - CNT_W'(1);
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (rst || flush) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      ram_cnt   <= '0;
      out_valid <= 1'b0;
    end else begin
      ram_cnt <= ram_cnt_next;
      if (wr_en) wr_ptr <= wr_ptr + AW'(1);
      if (rd_en) begin
        rd_ptr    <= rd_ptr + AW'(1);
        out_valid <= 1'b1;
      end else if (out_fire) begin
        out_valid <= 1'b0;
      end
    end
  end

  assign count       = ram_cnt + CNT_W'(out_valid);
  assign almost_full = (int'(count) >= ALMOST_FULL_LVL);

  simple_dpram_sclk #(
    .ADDR_WIDTH   (AW),
    .DATA_WIDTH   (DATA_WIDTH),
    .NUM_MEM      (DEPTH),
    .ENABLE_BYPASS(1'b1)
  ) u_ram (
    .clk  (clk),
    .raddr(rd_ptr),
    .rd_en(rd_en),
    .waddr(wr_ptr),
    .wr_en(wr_en),
    .din  (in_data),
    .dout (out_data)
  );

endmodule : sync_fifo_fwft

// File: tb/tb_sync_fifo_fwft.sv
// Self-checking bench for sync_fifo_fwft: a queue model of the FIFO contents
// checked against the DUT every cycle, plus directed literal expectations.
module tb_sync_fifo_fwft;

  localparam int DW    = 32;
  localparam int DEPTH = 16;
  localparam int AFL   = DEPTH - 2;
  localparam int CW    = fifo_pkg::cnt_width(DEPTH);

  logic          clk = 1'b0;
  logic          rst, flush, in_valid, in_ready, out_valid, out_ready, almost_full;
  logic [DW-1:0] in_data, out_data;
  logic [CW-1:0] count;

  int n_checks = 0;
  int n_fails  = 0;

  sync_fifo_fwft #(.DATA_WIDTH(DW), .DEPTH(DEPTH), .ALMOST_FULL_LVL(AFL)) dut (
    .clk(clk), .rst(rst), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .count(count), .almost_full(almost_full)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fails++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  // The FIFO is a queue of accepted-but-not-consumed words. The head is
  // visible whenever the queue is non-empty, total capacity is DEPTH+1.
  logic [DW-1:0] mq[$];
  bit started = 1'b0;

  always @(posedge clk) begin
    bit m_in_fire, m_out_fire;
    m_in_fire  = in_valid && !rst && (mq.size() < DEPTH + 1);
    m_out_fire = (mq.size() > 0) && out_ready;
    if (rst || flush) begin
      mq.delete();
    end else begin
      if (m_out_fire) void'(mq.pop_front());
      if (m_in_fire)  mq.push_back(in_data);
    end
    started = 1'b1;
  end

  // Compare process: outputs checked against the model on every falling edge.
  always @(negedge clk) begin
    if (started) begin
      check("cmp_in_ready",  in_ready,  (!rst && mq.size() < DEPTH + 1));
      check("cmp_out_valid", out_valid, (mq.size() > 0));
      check("cmp_count",     count,     mq.size());
      check("cmp_almost_full", almost_full, (mq.size() >= AFL));
      if (mq.size() > 0) check("cmp_out_data", out_data, mq[0]);
    end
  end

  // Producer rule: a stalled offer must stay put until accepted.
  logic          pv_valid = 1'b0, pv_ready = 1'b0;
  logic [DW-1:0] pv_data  = '0;
  always @(posedge clk) begin
    if (!rst && pv_valid && !pv_ready) begin
      check("producer_hold_valid", in_valid, 1'b1);
      check("producer_hold_data",  in_data,  pv_data);
    end
    pv_valid = in_valid && !rst;
    pv_ready = in_ready;
    pv_data  = in_data;
  end

  // Watchdog.
  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  // ---------------- stimulus helpers ----------------
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  int next_in, last_in, exp_out;

  // Drives words next_in..last_in-1 and consumes until all have emerged.
  // mode 0: out_ready always 1; mode 1: random 50% out_ready.
  task automatic stream(input int mode, input bit check_max, output int cycles);
    bit in_acc, out_acc;
    cycles = 0;
    while (exp_out < last_in && cycles < 2000) begin
      in_valid  = (next_in < last_in);
      in_data   = DW'(next_in);
      out_ready = (mode == 0) ? 1'b1 : 1'($urandom_range(0, 1));
      in_acc    = in_valid && in_ready;
      out_acc   = out_valid && out_ready;
      if (out_acc) begin
        check("stream_order", out_data, DW'(exp_out));
        exp_out++;
      end
      if (check_max) check("stream_count_le2", (count <= 2), 1'b1);
      step();
      cycles++;
      if (in_acc) next_in++;
    end
    in_valid  = 1'b0;
    out_ready = 1'b0;
    if (exp_out < last_in) check("stream_timeout", exp_out, last_in);
  endtask

  // ---------------- directed test ----------------
  initial begin
    int cyc;
    rst = 1'b1; flush = 1'b0; in_valid = 1'b1; in_data = 32'hDEAD_BEEF; out_ready = 1'b0;

    // Reset held 3 cycles with a word offered throughout.
    repeat (3) begin
      step();
      check("rst_in_ready",  in_ready,  1'b0);
      check("rst_out_valid", out_valid, 1'b0);
      check("rst_count",     count,     0);
    end
    rst = 1'b0; in_valid = 1'b0;
    step();
    check("rel_in_ready", in_ready, 1'b1);
    repeat (2) begin
      step();
      check("rel_no_stale", out_valid, 1'b0);
    end

    // Write-through into an empty FIFO.
    out_ready = 1'b1; in_valid = 1'b1; in_data = 32'hA5A5_0001;
    step();
    in_valid = 1'b0;
    check("wt_out_valid", out_valid, 1'b1);
    check("wt_out_data",  out_data,  32'hA5A5_0001);
    check("wt_count1",    count,     1);
    step();
    check("wt_count0",    count,     0);
    check("wt_empty",     out_valid, 1'b0);
    out_ready = 1'b0;

    // Fill with the consumer stalled: 17 words fit.
    for (int i = 0; i <= DEPTH; i++) begin
      in_valid = 1'b1; in_data = DW'(i);
      check("fill_ready", in_ready, 1'b1);
      step();
      check("fill_count", count, i + 1);
      check("fill_af",    almost_full, (i + 1 >= 14));
    end
    in_data = DW'(DEPTH + 1);
    repeat (2) step();
    check("full_in_ready", in_ready, 1'b0);
    check("full_count",    count,    17);
    check("full_af",       almost_full, 1'b1);
    check("full_head",     out_data, 0);

    // Drain: first pop, then in_ready returns the following cycle.
    out_ready = 1'b1;
    check("drain_pre_ready", in_ready, 1'b0);
    check("drain_first",     out_data, 0);
    step();
    check("drain_ready_back", in_ready, 1'b1);
    exp_out = 1; next_in = DEPTH + 1; last_in = 21;
    stream(0, 1'b0, cyc);
    step();
    check("drain_empty", count, 0);

    // Back-to-back streaming with pointer wrap: one word per cycle.
    next_in = 1000; exp_out = 1000; last_in = 1100;
    stream(0, 1'b1, cyc);
    check("stream_cycles", cyc, 101);

    // Random backpressure.
    next_in = 2000; exp_out = 2000; last_in = 2040;
    stream(1, 1'b0, cyc);
    step();
    check("rand_empty", count, 0);

    // Build count=9 then flush with a coincident input word.
    out_ready = 1'b0;
    for (int i = 0; i < 9; i++) begin
      in_valid = 1'b1; in_data = DW'(3000 + i);
      step();
    end
    check("pre_flush_count", count, 9);
    flush = 1'b1; in_valid = 1'b1; in_data = 32'h0000_0BAD;
    step();
    flush = 1'b0; in_valid = 1'b0;
    check("flush_count",     count,     0);
    check("flush_out_valid", out_valid, 1'b0);
    step();
    check("flush_dropped",   out_valid, 1'b0);

    // Pointers restart cleanly after flush.
    out_ready = 1'b1; in_valid = 1'b1; in_data = 32'h5555_AAAA;
    step();
    in_valid = 1'b0;
    check("post_flush_data", out_data, 32'h5555_AAAA);
    step();
    check("post_flush_empty", count, 0);

    step();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule : tb_sync_fifo_fwft
